// File: rtl/br_ckpt_queue.sv
// rtl/br_ckpt_queue.sv - in-order conditional-branch checkpoint queue between ID and retire
// Drives bht retire training and issues a delayed history recovery on mispredict.
module br_ckpt_queue #(
    parameter int DEPTH     = 16,
    parameter int LOG_DEPTH = 4,
    parameter int BHR_W     = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             id_cond0,
    input  logic             id_cond1,
    input  logic [63:0]      id_NPC0,
    input  logic [63:0]      id_NPC1,
    input  logic [BHR_W-1:0] id_bhr0,
    input  logic [BHR_W-1:0] id_bhr1,
    input  logic             id_pred_taken0,
    input  logic             id_pred_taken1,
    input  logic [1:0]       rob_retire_num,
    input  logic             rob_is_cond0,
    input  logic             rob_is_cond1,
    input  logic             rob_taken0,
    input  logic             rob_taken1,
    output logic             id_stall,
    output logic             rob_retire_cond0,
    output logic             rob_retire_cond1,
    output logic [63:0]      rob_retire_NPC0,
    output logic [63:0]      rob_retire_NPC1,
    output logic [BHR_W-1:0] rob_retire_BHR0,
    output logic [BHR_W-1:0] rob_retire_BHR1,
    output logic             rob_actual_taken0,
    output logic             rob_actual_taken1,
    output logic             recover_cond,
    output logic [BHR_W-1:0] recover_bhr,
    output logic             q_err
);

    typedef enum logic [1:0] {ST_NORMAL, ST_PEND, ST_RECOVER} state_t;

    localparam logic [LOG_DEPTH:0] DEPTH_C = (LOG_DEPTH+1)'(DEPTH);

    state_t state_q, state_d;
    logic [LOG_DEPTH-1:0] head_q, head_d, tail_q, tail_d;
    logic [LOG_DEPTH:0]   count_q, count_d;
    logic [BHR_W-1:0]     rec_bhr_q, rec_bhr_d;
    logic                 q_err_q, q_err_d;

    logic                 rc0_q, rc0_d, rc1_q, rc1_d;
    logic [63:0]          rn0_q, rn0_d, rn1_q, rn1_d;
    logic [BHR_W-1:0]     rb0_q, rb0_d, rb1_q, rb1_d;
    logic                 ra0_q, ra0_d, ra1_q, ra1_d;

    logic [63:0]          npc_mem_q  [DEPTH];
    logic [BHR_W-1:0]     bhr_mem_q  [DEPTH];
    logic                 pred_mem_q [DEPTH];

    logic                 wr0_en, wr1_en;
    logic [LOG_DEPTH-1:0] wr1_idx, rd1_idx;
    logic [1:0]           n_req, pop_cnt;
    logic                 enq_ok, eff0, eff1, mis;
    logic [LOG_DEPTH:0]   free_w;

    assign free_w = DEPTH_C - count_q;

    always_comb begin
        state_d   = state_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        rec_bhr_d = rec_bhr_q;
        q_err_d   = q_err_q;
        rc0_d = 1'b0; rn0_d = '0; rb0_d = '0; ra0_d = 1'b0;
        rc1_d = 1'b0; rn1_d = '0; rb1_d = '0; ra1_d = 1'b0;
        wr0_en  = 1'b0;
        wr1_en  = 1'b0;
        wr1_idx = tail_q;
        rd1_idx = head_q;
        mis     = 1'b0;
        pop_cnt = 2'd0;
        n_req   = {1'b0, id_cond0} + {1'b0, id_cond1};
        enq_ok  = free_w >= (LOG_DEPTH+1)'(n_req);
        eff0    = (rob_retire_num == 2'd1) || (rob_retire_num == 2'd2);
        eff1    = (rob_retire_num == 2'd2);

        case (state_q)
            ST_NORMAL: begin
                if (n_req != 2'd0 && !enq_ok) q_err_d = 1'b1;
                if (eff0 && rob_is_cond0) begin
                    if (count_q != '0) begin
                        rc0_d   = 1'b1;
                        rn0_d   = npc_mem_q[head_q];
                        rb0_d   = bhr_mem_q[head_q];
                        ra0_d   = rob_taken0;
                        pop_cnt = 2'd1;
                        if (pred_mem_q[head_q] != rob_taken0) begin
                            mis       = 1'b1;
                            rec_bhr_d = {bhr_mem_q[head_q][BHR_W-2:0], rob_taken0};
                        end
                    end else begin
                        q_err_d = 1'b1;
                    end
                end
                // a slot0 mispredict squashes slot1, so it is neither popped nor trained
                if (eff1 && rob_is_cond1 && !mis) begin
                    rd1_idx = head_q + LOG_DEPTH'(pop_cnt);
                    if (count_q > (LOG_DEPTH+1)'(pop_cnt)) begin
                        rc1_d   = 1'b1;
                        rn1_d   = npc_mem_q[rd1_idx];
                        rb1_d   = bhr_mem_q[rd1_idx];
                        ra1_d   = rob_taken1;
                        pop_cnt = pop_cnt + 2'd1;
                        if (pred_mem_q[rd1_idx] != rob_taken1) begin
                            mis       = 1'b1;
                            rec_bhr_d = {bhr_mem_q[rd1_idx][BHR_W-2:0], rob_taken1};
                        end
                    end else begin
                        q_err_d = 1'b1;
                    end
                end
                if (mis) begin
                    head_d  = '0;
                    tail_d  = '0;
                    count_d = '0;
                    state_d = ST_PEND;
                end else begin
                    head_d = head_q + LOG_DEPTH'(pop_cnt);
                    if (enq_ok) begin
                        wr0_en  = id_cond0;
                        wr1_en  = id_cond1;
                        wr1_idx = tail_q + LOG_DEPTH'(id_cond0);
                        tail_d  = tail_q + LOG_DEPTH'(n_req);
                        count_d = count_q + (LOG_DEPTH+1)'(n_req) - (LOG_DEPTH+1)'(pop_cnt);
                    end else begin
                        count_d = count_q - (LOG_DEPTH+1)'(pop_cnt);
                    end
                end
            end
            ST_PEND:    state_d = ST_RECOVER;
            ST_RECOVER: state_d = ST_NORMAL;
            default:    state_d = ST_NORMAL;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_NORMAL;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            rec_bhr_q <= '0;
            q_err_q   <= 1'b0;
            rc0_q <= 1'b0; rn0_q <= '0; rb0_q <= '0; ra0_q <= 1'b0;
            rc1_q <= 1'b0; rn1_q <= '0; rb1_q <= '0; ra1_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            rec_bhr_q <= rec_bhr_d;
            q_err_q   <= q_err_d;
            rc0_q <= rc0_d; rn0_q <= rn0_d; rb0_q <= rb0_d; ra0_q <= ra0_d;
            rc1_q <= rc1_d; rn1_q <= rn1_d; rb1_q <= rb1_d; ra1_q <= ra1_d;
        end
    end

    always_ff @(posedge clock) begin
        if (wr0_en) begin
            npc_mem_q[tail_q]  <= id_NPC0;
            bhr_mem_q[tail_q]  <= id_bhr0;
            pred_mem_q[tail_q] <= id_pred_taken0;
        end
        if (wr1_en) begin
            npc_mem_q[wr1_idx]  <= id_NPC1;
            bhr_mem_q[wr1_idx]  <= id_bhr1;
            pred_mem_q[wr1_idx] <= id_pred_taken1;
        end
    end

    assign id_stall          = (state_q == ST_NORMAL) && (free_w < (LOG_DEPTH+1)'(2));
    assign rob_retire_cond0  = rc0_q;
    assign rob_retire_cond1  = rc1_q;
    assign rob_retire_NPC0   = rn0_q;
    assign rob_retire_NPC1   = rn1_q;
    assign rob_retire_BHR0   = rb0_q;
    assign rob_retire_BHR1   = rb1_q;
    assign rob_actual_taken0 = ra0_q;
    assign rob_actual_taken1 = ra1_q;
    // the bht ignores training while recovering, so the pulse trails training by a cycle
    assign recover_cond      = (state_q == ST_RECOVER);
    assign recover_bhr       = (state_q == ST_RECOVER) ? rec_bhr_q : '0;
    assign q_err             = q_err_q;

endmodule
